kw11p: RTL and testbench

- Programmable real-time clock (KW11-P class) on the UNIBUS.
- Successor to the line-frequency clock. Adds:
  - a 16-bit count-set buffer and counter;
  - selectable tick rates;
  - up/down counting;
  - single/repeat modes;
  - error flag on missed service.
- Sits on the wired-OR bus beside the serial lines and the line clock, in the BG daisy chain.
- Interrupts at a parametrised BR level and vector.

---
 rtl/kw11p.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_kw11p.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kw11p.sv
// kw11p -- KW11-P class programmable real-time clock, UNIBUS slave and
// interrupting device.
//
// Registers (word offsets from ADDR):
//   +0 CSR  15 ERR(ro) 7 DONE(ro) 6 IE 5 FIX(wo) 4 UP 3 REPEAT 2:1 RATE 0 RUN
//   +2 CSB  count-set buffer, write-only (reads 0); a write also loads CTR
//   +4 CTR  16-bit counter, read-only
//
// RATE: 00 = 100 kHz, 01 = 10 kHz, 10 = LINE_HZ, 11 = external input.
// Optional build macro KW11P_EXTCLK_EN: when defined, ext_clk is
// synchronised and each rising edge is a tick at RATE=11; otherwise
// ext_clk is ignored and RATE=11 only counts FIX ticks.
//
// Ports:
//   clk, reset         system clock, asynchronous active-low reset
//   bus_init           UNIBUS INIT, synchronous clear
//   bus_d, bus_addr    data and address lines (inputs)
//   bus_c0, bus_c1     cycle type (DATI / DATO / DATOB)
//   bus_bbsy, bus_msyn, bus_ssyn, bus_sack, bus_intr   bus control inputs
//   bus_bg_in/out      bus-grant daisy chain (levels 4..7 on bits 0..3)
//   bus_br             bus request, only bit BR-4 is ever driven
//   bus_*_out          control and data lines driven by this device
//   ext_clk            external rate input
module kw11p #(
  parameter logic [17:0] ADDR    = 18'o772540,  // must be 8-byte aligned
  parameter logic [15:0] VEC     = 16'o104,
  parameter int          BR      = 6,
  parameter int          CLK_HZ  = 50_000_000,
  parameter int          LINE_HZ = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_init,
  input  logic [15:0] bus_d,
  input  logic [17:0] bus_addr,
  input  logic        bus_c0,
  input  logic        bus_c1,
  input  logic        bus_bbsy,
  input  logic        bus_msyn,
  input  logic        bus_ssyn,
  input  logic        bus_sack,
  input  logic        bus_intr,
  input  logic [3:0]  bus_bg_in,
  output logic [3:0]  bus_bg_out,
  output logic [3:0]  bus_br,
  output logic        bus_ssyn_out,
  output logic        bus_sack_out,
  output logic        bus_bbsy_out,
  output logic        bus_intr_out,
  output logic [15:0] bus_d_out,
  input  logic        ext_clk
);

  // Bus levels 4..7 map onto bits 0..3 of the grant/request vectors.
  localparam int          BR_BIT  = BR - 4;
  localparam logic [3:0]  BR_MASK = 4'(1 << BR_BIT);

  localparam int unsigned DIV_100K = CLK_HZ / 100_000;
  localparam int unsigned DIV_LINE = CLK_HZ / LINE_HZ;
  localparam int          W_100K   = $clog2(DIV_100K + 1);
  localparam int          W_LINE   = $clog2(DIV_LINE + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD}    slv_state_t;
  typedef enum logic [1:0] {I_IDLE, I_SACK, I_MASTER} int_state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic              ie, up, rep, run, done, err;
  logic [1:0]        rate;
  logic [15:0]       csb, ctr;
  logic              fix_tick;
  logic              msyn_q;
  slv_state_t        slv_state;
  logic [15:0]       slave_data;
  int_state_t        int_state;
  logic              req;
  logic [15:0]       vec_data;

  logic [W_100K-1:0] cnt_100k;
  logic [3:0]        cnt_10k;
  logic [W_LINE-1:0] cnt_line;
  logic              tick_ext;

  // ---------------------------------------------------------------------
  // Free-running prescalers
  // ---------------------------------------------------------------------
  logic tick_100k, tick_10k, tick_line;

  assign tick_100k = (cnt_100k == W_100K'(DIV_100K - 1));
  assign tick_10k  = tick_100k && (cnt_10k == 4'd9);
  assign tick_line = (cnt_line == W_LINE'(DIV_LINE - 1));

  // NOTE: sequential state is assigned only with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would create
  // order-dependent simulation and mismatches against synthesis.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_100k <= '0;
      cnt_10k  <= '0;
      cnt_line <= '0;
    end else if (bus_init) begin
      cnt_100k <= '0;
      cnt_10k  <= '0;
      cnt_line <= '0;
    end else begin
      cnt_100k <= tick_100k ? '0 : cnt_100k + 1'b1;
      if (tick_100k) cnt_10k <= (cnt_10k == 4'd9) ? 4'd0 : cnt_10k + 4'd1;
      cnt_line <= tick_line ? '0 : cnt_line + 1'b1;
    end
  end

`ifdef KW11P_EXTCLK_EN
  // Two synchroniser flops, third flop for rising-edge detection.
  logic [2:0] ext_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ext_sync <= '0;
    else if (bus_init) ext_sync <= '0;
    else               ext_sync <= {ext_sync[1:0], ext_clk};
  end

  assign tick_ext = ext_sync[1] & ~ext_sync[2];

  logic unused_ok;
  assign unused_ok = &{1'b0, bus_sack, bus_intr};
`else
  assign tick_ext = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus_sack, bus_intr, ext_clk};
`endif

  // ---------------------------------------------------------------------
  // Decode, read mux and counter next-state
  // ---------------------------------------------------------------------
  logic        reg_hit, start, wr_csr, wr_csb, rd_csr;
  logic [15:0] wr_mask, csr_image, csr_wr_val, csb_wr_val, rd_data;
  logic        rate_tick, count_tick, evt, ie_rise;
  logic [15:0] ctr_next;

  // NOTE: every always_comb output gets a default on entry, so no path
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    reg_hit    = 1'b0;
    start      = 1'b0;
    wr_mask    = 16'h0000;
    csr_image  = 16'h0000;
    csr_wr_val = 16'h0000;
    csb_wr_val = 16'h0000;
    rd_data    = 16'h0000;
    wr_csr     = 1'b0;
    wr_csb     = 1'b0;
    rd_csr     = 1'b0;
    rate_tick  = 1'b0;
    count_tick = 1'b0;
    ctr_next   = ctr;
    evt        = 1'b0;
    ie_rise    = 1'b0;

    // Offset +6 is not a register of this device.
    reg_hit = (bus_addr[17:3] == ADDR[17:3]) && (bus_addr[2:1] != 2'b11);
    start   = bus_msyn && !msyn_q && (slv_state == S_IDLE) && reg_hit;

    if (bus_c1) begin
      if (!bus_c0)         wr_mask = 16'hFFFF;
      else if (bus_addr[0]) wr_mask = 16'hFF00;
      else                 wr_mask = 16'h00FF;
    end

    csr_image  = {err, 7'b0, done, ie, 1'b0, up, rep, rate, run};
    csr_wr_val = (csr_image & ~wr_mask) | (bus_d & wr_mask);
    csb_wr_val = (csb & ~wr_mask) | (bus_d & wr_mask);

    wr_csr = start &&  bus_c1 && (bus_addr[2:1] == 2'b00);
    wr_csb = start &&  bus_c1 && (bus_addr[2:1] == 2'b01);
    rd_csr = start && !bus_c1 && (bus_addr[2:1] == 2'b00);

    case (bus_addr[2:1])
      2'b00:   rd_data = csr_image;
      2'b10:   rd_data = ctr;
      default: rd_data = 16'h0000;
    endcase

    case (rate)
      2'b00:   rate_tick = tick_100k;
      2'b01:   rate_tick = tick_10k;
      2'b10:   rate_tick = tick_line;
      default: rate_tick = tick_ext;
    endcase

    // FIX ticks count regardless of RUN; they are only generated while
    // the clock is stopped.
    count_tick = (run && rate_tick) || fix_tick;

    if (up) begin
      ctr_next = ctr + 16'd1;
      evt      = count_tick && (ctr == 16'hFFFF);
    end else begin
      ctr_next = ctr - 16'd1;                      // 0 wraps with no event
      evt      = count_tick && (ctr == 16'd1);
    end

    ie_rise = wr_csr && csr_wr_val[6] && !ie && done;
  end

  // ---------------------------------------------------------------------
  // Registers, counting and slave handshake
  // ---------------------------------------------------------------------
  // NOTE: every register here, including the data-path words, takes the
  // asynchronous reset; the device has no memory arrays that could be
  // left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie <= 1'b0; up <= 1'b0; rep <= 1'b0; run <= 1'b0;
      done <= 1'b0; err <= 1'b0; rate <= 2'b00;
      csb <= '0; ctr <= '0; fix_tick <= 1'b0; msyn_q <= 1'b0;
      slv_state <= S_IDLE; slave_data <= '0; bus_ssyn_out <= 1'b0;
    end else if (bus_init) begin
      ie <= 1'b0; up <= 1'b0; rep <= 1'b0; run <= 1'b0;
      done <= 1'b0; err <= 1'b0; rate <= 2'b00;
      csb <= '0; ctr <= '0; fix_tick <= 1'b0; msyn_q <= 1'b0;
      slv_state <= S_IDLE; slave_data <= '0; bus_ssyn_out <= 1'b0;
    end else begin
      msyn_q   <= bus_msyn;
      fix_tick <= 1'b0;

      if (evt) begin
        done <= 1'b1;
        // A same-clock CSR read loses to the event: ERR keeps its value.
        if (!rd_csr) err <= err | done;
        if (rep) begin
          ctr <= csb;
        end else begin
          ctr <= ctr_next;
          run <= 1'b0;
        end
      end else if (count_tick) begin
        ctr <= ctr_next;
      end

      // DATI of CSR: data is latched below from the pre-clear image.
      if (rd_csr && !evt) begin
        done <= 1'b0;
        err  <= 1'b0;
      end

      // Later assignments override the event's RUN clear and CTR update.
      if (wr_csr) begin
        ie       <= csr_wr_val[6];
        up       <= csr_wr_val[4];
        rep      <= csr_wr_val[3];
        rate     <= csr_wr_val[2:1];
        run      <= csr_wr_val[0];
        fix_tick <= csr_wr_val[5] && !csr_wr_val[0];
      end

      if (wr_csb) begin
        csb <= csb_wr_val;
        ctr <= csb_wr_val;
      end

      case (slv_state)
        S_IDLE: begin
          if (start) begin
            slave_data <= bus_c1 ? 16'h0000 : rd_data;
            slv_state  <= S_ACK;
          end
        end
        S_ACK: begin
          if (!bus_msyn) begin
            slave_data <= '0;
            slv_state  <= S_IDLE;
          end else begin
            bus_ssyn_out <= 1'b1;
            slv_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!bus_msyn) begin
            bus_ssyn_out <= 1'b0;
            slave_data   <= '0;
            slv_state    <= S_IDLE;
          end
        end
        default: slv_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt request and bus-master handshake
  // ---------------------------------------------------------------------
  logic req_set;
  assign req_set = (evt && ie) || ie_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_state <= I_IDLE; req <= 1'b0; vec_data <= '0;
      bus_sack_out <= 1'b0; bus_bbsy_out <= 1'b0; bus_intr_out <= 1'b0;
    end else if (bus_init) begin
      int_state <= I_IDLE; req <= 1'b0; vec_data <= '0;
      bus_sack_out <= 1'b0; bus_bbsy_out <= 1'b0; bus_intr_out <= 1'b0;
    end else begin
      case (int_state)
        I_IDLE: begin
          if (req && bus_bg_in[BR_BIT]) begin
            bus_sack_out <= 1'b1;
            int_state    <= I_SACK;
          end else if (req_set) begin
            req <= 1'b1;
          end else if (!ie) begin
            req <= 1'b0;            // IE cleared before the grant arrived
          end
        end
        I_SACK: begin
          if (!bus_bbsy && !bus_msyn && !bus_ssyn) begin
            bus_sack_out <= 1'b0;
            bus_bbsy_out <= 1'b1;
            bus_intr_out <= 1'b1;
            vec_data     <= VEC;
            int_state    <= I_MASTER;
          end
        end
        I_MASTER: begin
          if (bus_ssyn) begin
            bus_bbsy_out <= 1'b0;
            bus_intr_out <= 1'b0;
            vec_data     <= '0;
            req          <= req_set;  // keep an event that lands right now
            int_state    <= I_IDLE;
          end
        end
        default: int_state <= I_IDLE;
      endcase
    end
  end

  // Grant is withheld while a request is pending or being serviced;
  // otherwise it ripples straight through to downstream devices.
  logic grant_hold;
  assign grant_hold = req || (int_state != I_IDLE);

  assign bus_bg_out = reset ? (bus_bg_in & ~(grant_hold ? BR_MASK : 4'b0000))
                            : 4'b0000;
  assign bus_br     = req ? BR_MASK : 4'b0000;
  assign bus_d_out  = slave_data | vec_data;

endmodule

// File: tb/tb_kw11p.sv
// tb_kw11p -- self-checking bench for kw11p: directed bus sequences plus a
// randomized FIX-tick sequence checked against a counting reference model.
`timescale 1ns/1ps
module tb_kw11p;

  localparam logic [17:0] CSR_A = 18'o772540;
  localparam logic [17:0] CSB_A = 18'o772542;
  localparam logic [17:0] CTR_A = 18'o772544;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_init = 1'b0;
  logic [15:0] bus_d = '0;
  logic [17:0] bus_addr = '0;
  logic        bus_c0 = 1'b0, bus_c1 = 1'b0;
  logic        bus_bbsy = 1'b0, bus_msyn = 1'b0, bus_ssyn = 1'b0;
  logic        bus_sack = 1'b0, bus_intr = 1'b0;
  logic [3:0]  bus_bg_in = '0;
  logic [3:0]  bus_bg_out, bus_br;
  logic        bus_ssyn_out, bus_sack_out, bus_bbsy_out, bus_intr_out;
  logic [15:0] bus_d_out;
  logic        ext_clk = 1'b0;

  kw11p #(.CLK_HZ(1_000_000)) dut (
    .clk(clk), .reset(reset), .bus_init(bus_init),
    .bus_d(bus_d), .bus_addr(bus_addr), .bus_c0(bus_c0), .bus_c1(bus_c1),
    .bus_bbsy(bus_bbsy), .bus_msyn(bus_msyn), .bus_ssyn(bus_ssyn),
    .bus_sack(bus_sack), .bus_intr(bus_intr),
    .bus_bg_in(bus_bg_in), .bus_bg_out(bus_bg_out), .bus_br(bus_br),
    .bus_ssyn_out(bus_ssyn_out), .bus_sack_out(bus_sack_out),
    .bus_bbsy_out(bus_bbsy_out), .bus_intr_out(bus_intr_out),
    .bus_d_out(bus_d_out), .ext_clk(ext_clk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
      end
  endtask

  // One complete slave cycle; inputs change on the falling edge.
  task automatic bus_cycle(input logic [17:0] a, input logic c1,
                           input logic c0, input logic [15:0] wd,
                           output logic [15:0] rd);
    @(negedge clk);
    bus_addr = a; bus_c1 = c1; bus_c0 = c0;
    bus_d = c1 ? wd : 16'h0000;
    bus_msyn = 1'b1;
    for (int i = 0; i < 20 && bus_ssyn_out !== 1'b1; i++) @(negedge clk);
    check("ssyn_assert", bus_ssyn_out, 1);
    rd = bus_d_out;
    bus_msyn = 1'b0;
    @(negedge clk);
    check("ssyn_release", {bus_ssyn_out, bus_d_out}, 0);
    bus_d = 16'h0000; bus_c1 = 1'b0; bus_c0 = 1'b0;
  endtask

  task automatic rd(input logic [17:0] a, output logic [15:0] d);
    bus_cycle(a, 1'b0, 1'b0, 16'h0000, d);
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d);
    logic [15:0] unused_d;
    bus_cycle(a, 1'b1, 1'b0, d, unused_d);
  endtask

  task automatic wrb(input logic [17:0] a, input logic [15:0] d);
    logic [15:0] unused_d;
    bus_cycle(a, 1'b1, 1'b1, d, unused_d);
  endtask

  // Reference model of the counter for FIX-tick stepping.
  logic [15:0] m_ctr, m_csb;
  bit          m_done, m_err, m_up, m_rep;

  task automatic model_tick();
    bit ev;
    ev = 0;
    if (m_up) begin
      m_ctr = m_ctr + 16'd1;
      ev = (m_ctr == 16'd0);
    end else if (m_ctr == 16'd0) begin
      m_ctr = 16'hFFFF;
    end else begin
      m_ctr = m_ctr - 16'd1;
      ev = (m_ctr == 16'd0);
    end
    if (ev) begin
      if (m_done) m_err = 1;
      m_done = 1;
      if (m_rep) m_ctr = m_csb;
    end
  endtask

  function automatic logic [15:0] m_csr();
    return {m_err, 7'b0, m_done, 2'b00, m_up, m_rep, 3'b110};
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v, prev, expv, mode;
    int          ev;

    // ---- reset ----
    bus_bg_in = 4'b0100;
    #12;
    check("reset_outputs", {bus_bg_out, bus_br, bus_ssyn_out, bus_sack_out,
                            bus_bbsy_out, bus_intr_out, bus_d_out}, 0);
    @(negedge clk); reset = 1'b1;
    #1 check("bg_passthrough", bus_bg_out, 4'b0100);
    check("idle_outputs", {bus_br, bus_ssyn_out, bus_sack_out, bus_bbsy_out,
                           bus_intr_out, bus_d_out}, 0);
    bus_bg_in = 4'b0000;
    rd(CSR_A, v); check("reset_csr", v, 0);
    rd(CTR_A, v); check("reset_ctr", v, 0);
    rd(CSB_A, v); check("reset_csb", v, 0);

    // ---- single-shot down count at 100 kHz ----
    wr(CSB_A, 16'd3);
    rd(CTR_A, v); check("csb_loads_ctr", v, 3);
    wr(CSR_A, 16'o001);
    prev = 16'd3;
    for (int i = 0; i < 100 && prev != 16'd0; i++) begin
      rd(CTR_A, v);
      if (v !== prev) begin
        check("down_step", v, prev - 16'd1);
        prev = v;
      end
    end
    check("down_reached_zero", prev, 0);
    rd(CSR_A, v); check("single_done", v, 16'o200);
    repeat (30) @(negedge clk);
    rd(CTR_A, v); check("single_stopped", v, 0);
    rd(CSR_A, v); check("done_cleared_by_read", v, 16'o000);

    // ---- repeat mode at 10 kHz, two unserviced events ----
    wr(CSB_A, 16'd2);
    wr(CSR_A, 16'o013);
    prev = 16'd2;
    ev = 0;
    for (int i = 0; i < 400 && ev < 2; i++) begin
      rd(CTR_A, v);
      if (v !== prev) begin
        expv = (prev == 16'd1) ? 16'd2 : prev - 16'd1;
        check("repeat_step", v, expv);
        if (prev == 16'd1) ev++;
        prev = v;
      end
    end
    check("repeat_events", ev, 2);
    rd(CSR_A, v); check("repeat_err_done", v, 16'o100213);
    rd(CSR_A, v); check("repeat_cleared", v, 16'o013);
    wr(CSR_A, 16'o000);

    // ---- up / repeat wrap with FIX ticks ----
    wr(CSB_A, 16'o177776);
    wr(CSR_A, 16'o076);
    rd(CTR_A, v); check("fix_up_1", v, 16'o177777);
    rd(CSR_A, v); check("fix_up_no_event", v, 16'o036);
    wr(CSR_A, 16'o076);
    rd(CTR_A, v); check("fix_wrap_reload", v, 16'o177776);
    rd(CSR_A, v); check("fix_wrap_done", v, 16'o236);

    // ---- interrupt request and bus-master handshake ----
    wr(CSB_A, 16'd1);
    wr(CSR_A, 16'o146);
    check("br_raised", bus_br, 4'b0100);
    rd(CSR_A, v); check("irq_csr", v, 16'o306);
    check("br_held", bus_br, 4'b0100);
    bus_bbsy = 1'b1;
    @(negedge clk); bus_bg_in = 4'b0100;
    for (int i = 0; i < 20 && bus_sack_out !== 1'b1; i++) @(negedge clk);
    check("sack_taken", bus_sack_out, 1);
    check("grant_withheld", bus_bg_out, 4'b0000);
    bus_bg_in = 4'b0000;
    repeat (3) @(negedge clk);
    check("wait_for_bbsy", {bus_sack_out, bus_bbsy_out, bus_intr_out}, 3'b100);
    bus_bbsy = 1'b0;
    for (int i = 0; i < 20 && bus_bbsy_out !== 1'b1; i++) @(negedge clk);
    check("master_lines", {bus_sack_out, bus_bbsy_out, bus_intr_out}, 3'b011);
    check("vector", bus_d_out, 16'o104);
    bus_ssyn = 1'b1;
    @(negedge clk);
    check("released", {bus_bbsy_out, bus_intr_out, bus_br, bus_d_out}, 0);
    bus_ssyn = 1'b0;

    // ---- IE 0->1 with DONE, and withdrawal ----
    wr(CSB_A, 16'd1);
    wr(CSR_A, 16'o046);
    check("no_req_without_ie", bus_br, 4'b0000);
    wr(CSR_A, 16'o106);
    check("ie_rise_req", bus_br, 4'b0100);
    wr(CSR_A, 16'o006);
    check("ie_withdraw", bus_br, 4'b0000);
    @(negedge clk); bus_bg_in = 4'b0100;
    #1 check("bg_pass_again", bus_bg_out, 4'b0100);
    bus_bg_in = 4'b0000;
    rd(CSR_A, v); check("withdraw_csr", v, 16'o206);

    // ---- byte writes ----
    wr(CSR_A, 16'o107);
    wrb(CSR_A + 18'd1, 16'o177400);
    rd(CSR_A, v); check("datob_high_csr", v, 16'o107);
    wr(CSB_A, 16'h1234);
    wrb(CSB_A, 16'h00AB);
    rd(CTR_A, v); check("datob_csb_low", v, 16'h12AB);
    wrb(CSB_A + 18'd1, 16'hCD00);
    rd(CTR_A, v); check("datob_csb_high", v, 16'hCDAB);
    rd(CSB_A, v); check("csb_reads_zero", v, 0);
    wr(CSR_A, 16'o006);
    check("no_req_after_datob", bus_br, 4'b0000);

    // ---- randomized FIX stepping against the model ----
    rd(CSR_A, v);
    m_done = 0; m_err = 0; m_up = 0; m_rep = 0;
    m_csb = 16'hCDAB; m_ctr = 16'hCDAB;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 5))
            0: m_csb = 16'h0000;
            1: m_csb = 16'h0001;
            2: m_csb = 16'h0002;
            3: m_csb = 16'hFFFF;
            4: m_csb = 16'hFFFE;
            default: m_csb = 16'($urandom());
          endcase
          m_ctr = m_csb;
          wr(CSB_A, m_csb);
          m_up  = 1'($urandom_range(0, 1));
          m_rep = 1'($urandom_range(0, 1));
          mode = {11'b0, m_up, m_rep, 3'b110};
          wr(CSR_A, mode);
        end
        1: begin
          mode = {10'b0, 1'b1, m_up, m_rep, 3'b110};
          for (int k = $urandom_range(1, 3); k > 0; k--) begin
            wr(CSR_A, mode);
            model_tick();
          end
        end
        2: begin
          rd(CTR_A, v); check("rand_ctr", v, m_ctr);
        end
        default: begin
          rd(CSR_A, v); check("rand_csr", v, m_csr());
          m_done = 0; m_err = 0;
        end
      endcase
    end
    rd(CTR_A, v); check("rand_final_ctr", v, m_ctr);
    rd(CSR_A, v); check("rand_final_csr", v, m_csr());

    // ---- bus_init clears everything ----
    wr(CSB_A, 16'd5);
    rd(CTR_A, v); check("pre_init_ctr", v, 5);
    @(negedge clk); bus_init = 1'b1;
    @(negedge clk); bus_init = 1'b0;
    rd(CTR_A, v); check("init_ctr", v, 0);
    rd(CSR_A, v); check("init_csr", v, 0);

    // ---- reset in the middle of a slave cycle ----
    wr(CSB_A, 16'o123);
    @(negedge clk);
    bus_addr = CTR_A; bus_c1 = 1'b0; bus_c0 = 1'b0; bus_msyn = 1'b1;
    for (int i = 0; i < 20 && bus_ssyn_out !== 1'b1; i++) @(negedge clk);
    check("mid_ssyn_up", {bus_ssyn_out, bus_d_out}, {1'b1, 16'o123});
    #2 reset = 1'b0;
    #1 check("mid_reset_drop", {bus_ssyn_out, bus_sack_out, bus_bbsy_out,
                                bus_intr_out, bus_d_out}, 0);
    bus_msyn = 1'b0;
    @(negedge clk); reset = 1'b1;
    rd(CTR_A, v); check("post_reset_ctr", v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
